// File: rtl/raster_pkg.sv
// Shared definitions for the raster stream transmitter: FSM state encoding,
// saturation limit and pixel-lane sizing helper.
package raster_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SOF    = 3'd1,
    LINE   = 3'd2,
    HBLANK = 3'd3,
    EOF    = 3'd4
  } tx_state_t;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  function automatic int pixcnt_bits(input int pixcnt);
    return $clog2(pixcnt);
  endfunction

endpackage

// File: rtl/raster_frame_tx_if.sv
// Upstream ready/valid pixel source plus downstream raster stream, bundled so the
// transmitter sits between them through a single port.
interface raster_frame_tx_if #(
  parameter int DWIDTH = 10,
  parameter int PIXCNT = 8
);

  logic [DWIDTH*PIXCNT-1:0] s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic                     new_frame;
  logic [DWIDTH*PIXCNT-1:0] data_out;
  logic                     out_vld;

  // master: the transmitter; slave: the source/sink environment around it
  modport master (
    input  s_data,
    input  s_valid,
    output s_ready,
    output new_frame,
    output data_out,
    output out_vld
  );

  modport slave (
    output s_data,
    output s_valid,
    input  s_ready,
    input  new_frame,
    input  data_out,
    input  out_vld
  );

endinterface

// File: rtl/raster_ramp_pattern.sv
// Combinational ramp test word: pixel k of beat b in row r is (b*PIXCNT + k + r)
// truncated to DWIDTH bits.
module raster_ramp_pattern
  import raster_pkg::*;
#(
  parameter int DWIDTH = 10,
  parameter int PIXCNT = 8,
  parameter int BW     = 9,
  parameter int RW     = 12
) (
  input  logic [BW-1:0]            beat,
  input  logic [RW-1:0]            row,
  output logic [DWIDTH*PIXCNT-1:0] word
);

  localparam int PB = pixcnt_bits(PIXCNT);

  logic [DWIDTH-1:0] base_s;

  assign base_s = (DWIDTH'(beat) << PB) + DWIDTH'(row);

  // one lane per pixel, each offset by its position within the beat
  always_comb begin
    word = '0;
    for (int k = 0; k < PIXCNT; k++) begin
      word[k*DWIDTH +: DWIDTH] = base_s + DWIDTH'(k);
    end
  end

endmodule

// File: rtl/raster_frame_tx.sv
// Raster stream transmitter: frames upstream or ramp pixel words into rows x cols
// with horizontal blanking, reporting frame completion and source underruns.
module raster_frame_tx
  import raster_pkg::*;
#(
  parameter int DWIDTH = 10,
  parameter int PIXCNT = 8,
  parameter int ROWS   = 2049,
  parameter int COLS   = 2448,
  parameter int GAPW   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pattern_en,
  input  logic [$clog2(ROWS)-1:0]   rows,
  input  logic [$clog2(COLS)-1:0]   cols,
  input  logic [GAPW-1:0]           hblank,
  raster_frame_tx_if.master         bus,
  output logic                      busy,
  output logic                      frame_done,
  output logic [15:0]               underrun_cnt
);

  localparam int PB = pixcnt_bits(PIXCNT);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int BW = CW - PB;
  localparam int WW = DWIDTH * PIXCNT;

  tx_state_t         state_r, state_s;
  logic [RW-1:0]     rows_r, rows_s, row_r, row_s;
  logic [BW-1:0]     bpl_r, bpl_s, beat_r, beat_s;
  logic [GAPW-1:0]   hblank_r, hblank_s, gap_r, gap_s;
  logic              pat_r, pat_s;
  logic              new_frame_r, new_frame_s;
  logic [WW-1:0]     data_out_r, data_out_s;
  logic              out_vld_r, out_vld_s;
  logic              busy_r, busy_s;
  logic              frame_done_r, frame_done_s;
  logic [15:0]       underrun_r, underrun_s;
  logic              fire_s;
  logic [WW-1:0]     ramp_s;
  logic [BW-1:0]     cols_bpl_s;
  logic              cols_unused_s;

  // sub-beat column bits carry no meaning; only whole beats are framed
  assign cols_bpl_s    = cols[CW-1:PB];
  assign cols_unused_s = ^cols[PB-1:0];

  raster_ramp_pattern #(
    .DWIDTH (DWIDTH),
    .PIXCNT (PIXCNT),
    .BW     (BW),
    .RW     (RW)
  ) u_ramp (
    .beat (beat_r),
    .row  (row_r),
    .word (ramp_s)
  );

  // next-state, counters and next output values
  always_comb begin
    state_s      = state_r;
    rows_s       = rows_r;
    bpl_s        = bpl_r;
    hblank_s     = hblank_r;
    pat_s        = pat_r;
    row_s        = row_r;
    beat_s       = beat_r;
    gap_s        = gap_r;
    new_frame_s  = 1'b0;
    frame_done_s = 1'b0;
    out_vld_s    = 1'b0;
    data_out_s   = data_out_r;
    busy_s       = busy_r;
    underrun_s   = underrun_r;
    fire_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          rows_s   = rows;
          bpl_s    = cols_bpl_s;
          hblank_s = hblank;
          pat_s    = pattern_en;
          if ((rows != '0) && (cols_bpl_s != '0)) begin
            state_s     = SOF;
            new_frame_s = 1'b1;
            busy_s      = 1'b1;
          end else begin
            state_s      = EOF;
            frame_done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SOF: begin
        state_s = LINE;
        beat_s  = '0;
        row_s   = '0;
      end
      LINE: begin
        fire_s = pat_r | bus.s_valid;
        if (fire_s) begin
          out_vld_s  = 1'b1;
          data_out_s = pat_r ? ramp_s : bus.s_data;
          if (beat_r == (bpl_r - BW'(1'b1))) begin
            beat_s = '0;
            if (row_r == (rows_r - RW'(1'b1))) begin
              state_s      = EOF;
              frame_done_s = 1'b1;
              busy_s       = 1'b0;
            end else begin
              row_s = row_r + RW'(1'b1);
              if (hblank_r != '0) begin
                state_s = HBLANK;
                gap_s   = hblank_r;
              end else begin
                state_s = LINE;
              end
            end
          end else begin
            beat_s = beat_r + BW'(1'b1);
          end
        end else begin
          if (underrun_r != UNDERRUN_MAX) begin
            underrun_s = underrun_r + 16'd1;
          end else begin
            underrun_s = underrun_r;
          end
        end
      end
      HBLANK: begin
        gap_s = gap_r - GAPW'(1'b1);
        if (gap_r == GAPW'(1'b1)) begin
          state_s = LINE;
        end else begin
          state_s = HBLANK;
        end
      end
      EOF: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // latched frame configuration, position counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_r       <= '0;
      bpl_r        <= '0;
      hblank_r     <= '0;
      pat_r        <= 1'b0;
      row_r        <= '0;
      beat_r       <= '0;
      gap_r        <= '0;
      new_frame_r  <= 1'b0;
      frame_done_r <= 1'b0;
      out_vld_r    <= 1'b0;
      data_out_r   <= '0;
      busy_r       <= 1'b0;
      underrun_r   <= 16'd0;
    end else begin
      rows_r       <= rows_s;
      bpl_r        <= bpl_s;
      hblank_r     <= hblank_s;
      pat_r        <= pat_s;
      row_r        <= row_s;
      beat_r       <= beat_s;
      gap_r        <= gap_s;
      new_frame_r  <= new_frame_s;
      frame_done_r <= frame_done_s;
      out_vld_r    <= out_vld_s;
      data_out_r   <= data_out_s;
      busy_r       <= busy_s;
      underrun_r   <= underrun_s;
    end
  end

  // words are only requested from upstream while a line is being sent
  assign bus.s_ready   = (state_r == LINE) & ~pat_r;
  assign bus.new_frame = new_frame_r;
  assign bus.data_out  = data_out_r;
  assign bus.out_vld   = out_vld_r;
  assign busy          = busy_r;
  assign frame_done    = frame_done_r;
  assign underrun_cnt  = underrun_r;

endmodule

// File: tb/tb_raster_frame_tx.sv
// Self-checking bench for raster_frame_tx: directed vector table, random frames,
// and hand-written reset/underrun sequences checked against a frame-level model.
module tb_raster_frame_tx;

  localparam int DWIDTH = 10;
  localparam int PIXCNT = 8;
  localparam int ROWS   = 2049;
  localparam int COLS   = 2448;
  localparam int GAPW   = 8;
  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);
  localparam int WW     = DWIDTH * PIXCNT;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            pattern_en;
  logic [RW-1:0]   rows;
  logic [CW-1:0]   cols;
  logic [GAPW-1:0] hblank;
  logic            busy;
  logic            frame_done;
  logic [15:0]     underrun_cnt;

  raster_frame_tx_if #(.DWIDTH(DWIDTH), .PIXCNT(PIXCNT)) bus ();

  raster_frame_tx #(
    .DWIDTH (DWIDTH),
    .PIXCNT (PIXCNT),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .GAPW   (GAPW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pattern_en   (pattern_en),
    .rows         (rows),
    .cols         (cols),
    .hblank       (hblank),
    .bus          (bus),
    .busy         (busy),
    .frame_done   (frame_done),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  // vmode: 0 = source always valid, 1 = random valid, 2 = valid dropped in cycles 4..8
  typedef struct {
    bit pat;
    int nrows;
    int ncols;
    int h;
    int vmode;
    int extra;
    int exp_beats;
    int exp_done;
    int exp_stalls;
  } tv_t;

  int  checks    = 0;
  int  errors    = 0;
  int  exp_under = 0;
  tv_t tbl[10];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] ramp_word(input int b, input int r);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < PIXCNT; k++) begin
      w[k*DWIDTH +: DWIDTH] = DWIDTH'((b * PIXCNT + k + r) % (1 << DWIDTH));
    end
    return w;
  endfunction

  function automatic logic [WW-1:0] rand_word();
    return WW'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic check_reset_vals(input string tag);
    check_w({tag, "_new_frame"}, WW'(bus.new_frame), '0);
    check_w({tag, "_data_out"}, bus.data_out, '0);
    check_w({tag, "_out_vld"}, WW'(bus.out_vld), '0);
    check_w({tag, "_busy"}, WW'(busy), '0);
    check_w({tag, "_frame_done"}, WW'(frame_done), '0);
    check_w({tag, "_underrun"}, WW'(underrun_cnt), '0);
    check_w({tag, "_s_ready"}, WW'(bus.s_ready), '0);
  endtask

  task automatic run_frame(input string tag, input tv_t v);
    logic [WW-1:0] src_q[$];
    logic [WW-1:0] exp_q[$];
    int            vcyc[$];
    logic [WW-1:0] last_w;
    logic [WW-1:0] w;
    logic          vld;
    int bpl, nbeats, stalls, done_cyc, done_vld, nf_cnt, nf_cyc, vcnt;
    int hold_bad, sready_bad, busy_bad, extra_done, timing_bad, limit;
    bpl        = v.ncols / PIXCNT;
    nbeats     = v.nrows * bpl;
    stalls     = 0;
    done_cyc   = -1;
    done_vld   = 0;
    nf_cnt     = 0;
    nf_cyc     = -1;
    vcnt       = 0;
    hold_bad   = 0;
    sready_bad = 0;
    busy_bad   = 0;
    extra_done = 0;
    timing_bad = 0;
    last_w     = '0;
    if (v.pat) begin
      for (int r = 0; r < v.nrows; r++)
        for (int b = 0; b < bpl; b++)
          exp_q.push_back(ramp_word(b, r));
    end else begin
      for (int i = 0; i < nbeats + 4; i++) begin
        w = rand_word();
        src_q.push_back(w);
        if (i < nbeats) exp_q.push_back(w);
      end
    end
    limit = 4 * v.exp_done + 64;
    @(negedge clk);
    start      = 1'b1;
    pattern_en = v.pat;
    rows       = RW'(v.nrows);
    cols       = CW'(v.ncols);
    hblank     = GAPW'(v.h);
    for (int c = 0; c < limit; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) last_w = bus.data_out;
      if (bus.new_frame) begin
        nf_cnt++;
        nf_cyc = c;
      end
      if (bus.out_vld) begin
        vcnt++;
        vcyc.push_back(c);
        if (exp_q.size() > 0) check_w({tag, "_data"}, bus.data_out, exp_q.pop_front());
        last_w = bus.data_out;
      end else if (bus.data_out !== last_w) begin
        hold_bad++;
      end
      if (frame_done) begin
        if (done_cyc < 0) begin
          done_cyc = c;
          done_vld = int'(bus.out_vld);
        end else begin
          extra_done++;
        end
      end
      if (v.pat && bus.s_ready) sready_bad++;
      if (c >= 1 && nbeats > 0 && done_cyc < 0 && busy !== 1'b1) busy_bad++;
      if ((nbeats == 0 || (done_cyc >= 0 && c > done_cyc)) && busy !== 1'b0) busy_bad++;
      if (c > 0) begin
        start = (c == v.extra);
        if (c == v.extra) begin
          rows       = RW'(1);
          cols       = CW'(PIXCNT);
          hblank     = '0;
          pattern_en = ~v.pat;
        end
      end
      if (v.pat) vld = 1'($urandom_range(0, 1));
      else if (v.vmode == 0) vld = 1'b1;
      else if (v.vmode == 1) vld = ($urandom_range(0, 3) != 0);
      else vld = !(c >= 4 && c <= 8);
      bus.s_valid = vld;
      bus.s_data  = (vld && src_q.size() > 0) ? src_q[0] : rand_word();
      if (bus.s_ready && vld && src_q.size() > 0) void'(src_q.pop_front());
      if (bus.s_ready && !vld) stalls++;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start       = 1'b0;
    bus.s_valid = 1'b0;
    check({tag, "_done_seen"}, longint'(done_cyc >= 0), 1);
    if (done_cyc >= 0) check({tag, "_done_cycle"}, done_cyc, v.exp_done + stalls);
    if (v.exp_stalls >= 0) check({tag, "_stalls"}, stalls, v.exp_stalls);
    exp_under = (exp_under + stalls > 65535) ? 65535 : exp_under + stalls;
    check({tag, "_underrun_cnt"}, underrun_cnt, exp_under);
    check({tag, "_new_frame_cnt"}, nf_cnt, (nbeats > 0) ? 1 : 0);
    if (nbeats > 0) check({tag, "_new_frame_cycle"}, nf_cyc, 1);
    check({tag, "_beats"}, vcnt, v.exp_beats);
    if (nbeats > 0) check({tag, "_done_with_last_vld"}, done_vld, 1);
    check({tag, "_hold"}, hold_bad, 0);
    check({tag, "_s_ready_in_pattern"}, sready_bad, 0);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_extra_done"}, extra_done, 0);
    if (stalls == 0 && nbeats > 0 && vcyc.size() == nbeats) begin
      for (int i = 0; i < nbeats; i++)
        if (vcyc[i] != 3 + i + (i / bpl) * v.h) timing_bad++;
      check({tag, "_beat_timing"}, timing_bad, 0);
    end
  endtask

  initial begin
    tv_t rv;
    int  nb;
    // {pat, rows, cols, hblank, vmode, extra_start, beats, done_cycle, stalls}
    tbl[0] = '{1'b1, 4, 32, 3, 0, 0, 16, 27, 0};
    tbl[1] = '{1'b0, 2, 16, 0, 0, 0, 4, 6, 0};
    tbl[2] = '{1'b0, 1, 32, 0, 2, 0, 4, 6, 5};
    tbl[3] = '{1'b1, 0, 32, 2, 0, 0, 0, 1, 0};
    tbl[4] = '{1'b0, 3, 7, 1, 0, 0, 0, 1, 0};
    tbl[5] = '{1'b1, 3, 24, 0, 0, 4, 9, 11, 0};
    tbl[6] = '{1'b0, 3, 16, 2, 1, 0, 6, 12, -1};
    tbl[7] = '{1'b1, 1, 8, 5, 0, 0, 1, 3, 0};
    tbl[8] = '{1'b1, 2, 2440, 1, 0, 0, 610, 613, 0};
    tbl[9] = '{1'b0, 2, 71, 1, 0, 0, 16, 19, 0};

    reset       = 1'b1;
    start       = 1'b0;
    pattern_en  = 1'b0;
    rows        = '0;
    cols        = '0;
    hblank      = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_frame($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 12; i++) begin
      rv.pat   = 1'($urandom_range(0, 1));
      rv.nrows = $urandom_range(0, 4);
      rv.ncols = $urandom_range(0, 80);
      rv.h     = $urandom_range(0, 4);
      rv.vmode = rv.pat ? 0 : $urandom_range(0, 1);
      rv.extra = (i % 3 == 0) ? 5 : 0;
      nb       = rv.nrows * (rv.ncols / PIXCNT);
      rv.exp_beats  = nb;
      rv.exp_done   = (nb == 0) ? 1 : 2 + nb + (rv.nrows - 1) * rv.h;
      rv.exp_stalls = (rv.vmode == 1) ? -1 : 0;
      run_frame($sformatf("rnd%0d", i), rv);
    end

    // upstream frame stalled 3 cycles, then reset in the middle of row 1
    @(negedge clk);
    start       = 1'b1;
    pattern_en  = 1'b0;
    rows        = RW'(4);
    cols        = CW'(32);
    hblank      = GAPW'(2);
    bus.s_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c < 12) begin
        bus.s_valid = (c >= 5);
        bus.s_data  = rand_word();
      end
    end
    check("midline_busy", busy, 1);
    check("midline_out_vld", bus.out_vld, 1);
    check("midline_underrun", underrun_cnt, exp_under + 3);
    reset = 1'b1;
    #1;
    check_reset_vals("midline_reset");
    exp_under = 0;
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_frame("post_reset", tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
